// File: rtl/ps2_scancode_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_receiver_if
//  Description : Bundles the PS/2 pins and the key-event outputs of the
//                scancode receiver.
//                  ps2_clk, ps2_data : raw PS/2 pins (asynchronous)
//                  scancode[8:0]     : {extended flag, key byte}
//                  Pressed, Released : one-cycle make/break strobes
//                  frame_err         : one-cycle rejected-frame strobe
//                slave  : receiver side (pins in, key events out)
//                master : board/consumer side (pins out, key events in)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scancode_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [8:0] scancode;
  logic       Pressed;
  logic       Released;
  logic       frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scancode,
    output Pressed,
    output Released,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scancode,
    input  Pressed,
    input  Released,
    input  frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_scancode_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_scancode_receiver
//  Description : Receives PS/2 device-to-host frames, handles the Set-2
//                E0 (extended) and F0 (break) prefixes and emits complete
//                key events.
//  Ports       : clk  - system clock (only clock of the block)
//                rst  - synchronous, active-high reset
//                bus  - ps2_scancode_receiver_if.slave
//                       (ps2_clk/ps2_data in; scancode, Pressed, Released,
//                        frame_err out)
//  Parameters  : FILTER_LEN     - identical samples needed to move fclk
//                TIMEOUT_CYCLES - max clk cycles between in-frame edges
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  ps2_scancode_receiver_if.slave   bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    BYTE_EXT = 8'hE0;
  localparam logic [7:0]    BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Input conditioning
  logic          clk_s1, clk_s2;
  logic          dat_s1, dat_s2;
  logic          fclk, fclk_d;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      fclk    <= 1'b1;
      fclk_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
      fclk_d <= fclk;
      // Count consecutive samples that disagree with fclk; any agreeing
      // sample restarts the run.
      if (clk_s2 == fclk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FILT_MAX) begin
        fclk    <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = fclk_d & ~fclk;

  // Frame state machine and byte interpretation
  state_t        state, state_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [9:0]    shreg, shreg_next;     // {stop, parity, data[7:0]}
  logic [TW-1:0] timer, timer_next;
  logic          ext, ext_next;
  logic          brk, brk_next;
  logic [8:0]    code, code_next;
  logic          pressed, pressed_next;
  logic          released, released_next;
  logic          err, err_next;
  logic          frame_ok;

  // Stop bit must be 1 and data+parity must hold an odd number of ones.
  assign frame_ok = shreg[9] & (^shreg[8:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      timer    <= '0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      code     <= '0;
      pressed  <= 1'b0;
      released <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      shreg    <= shreg_next;
      timer    <= timer_next;
      ext      <= ext_next;
      brk      <= brk_next;
      code     <= code_next;
      pressed  <= pressed_next;
      released <= released_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    shreg_next    = shreg;
    timer_next    = timer;
    ext_next      = ext;
    brk_next      = brk;
    code_next     = code;
    pressed_next  = 1'b0;
    released_next = 1'b0;
    err_next      = 1'b0;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (fall) begin
          if (!dat_s2) begin
            state_next   = SHIFT;
            bit_cnt_next = 4'd1;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (fall) begin
          // LSB arrives first, so shifting right leaves data bit 0 at [0]
          // once the stop bit has landed at [9].
          shreg_next   = {dat_s2, shreg[9:1]};
          bit_cnt_next = bit_cnt + 4'd1;
          timer_next   = '0;
          if (bit_cnt == 4'd10) begin
            state_next = CHECK;
          end
        end else if (timer == TIME_MAX) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          timer_next   = '0;
          err_next     = 1'b1;
          ext_next     = 1'b0;
          brk_next     = 1'b0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      CHECK: begin
        // An edge arriving here is ignored.
        state_next   = IDLE;
        bit_cnt_next = '0;
        if (!frame_ok) begin
          err_next = 1'b1;
          ext_next = 1'b0;
          brk_next = 1'b0;
        end else if (shreg[7:0] == BYTE_EXT) begin
          ext_next = 1'b1;
        end else if (shreg[7:0] == BYTE_BRK) begin
          brk_next = 1'b1;
        end else begin
          code_next     = {ext, shreg[7:0]};
          released_next = brk;
          pressed_next  = ~brk;
          ext_next      = 1'b0;
          brk_next      = 1'b0;
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  assign bus.scancode  = code;
  assign bus.Pressed   = pressed;
  assign bus.Released  = released;
  assign bus.frame_err = err;

endmodule
`default_nettype wire

// File: doc/ps2_scancode_receiver.md
# ps2_scancode_receiver

Receives PS/2 device-to-host frames from the keyboard port and assembles them into 9-bit scancodes with make/break strobes. It sits between the board's PS/2 pins and the key-event decoder, which consumes `scancode` and `Released`. Set-2 prefixes are handled here: `E0` marks an extended key, and `F0` marks a break code. Downstream logic only sees complete key events.

## Interface

**Parameters**
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples needed before the filtered PS/2 clock changes state.
- `TIMEOUT_CYCLES`, default 200000: maximum number of `clk` cycles allowed between falling edges inside a frame (2 ms at 100 MHz).

**Ports** (clock and reset first)
- `clk`, input, 1: system clock. This is the only clock in the block.
- `rst`, input, 1: reset, synchronous and active-high.
- `ps2_clk`, input, 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`, input, 1: raw PS/2 data pin, asynchronous to `clk`.
- `scancode`, output, 9: bit 8 is the extended flag (`E0` was seen); bits 7:0 are the key byte. It holds its value until the next key event.
- `Pressed`, output, 1: one-cycle pulse for a make code.
- `Released`, output, 1: one-cycle pulse for a break code.
- `frame_err`, output, 1: one-cycle pulse when a frame is rejected.

## Operation

**Input conditioning**
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- The synchronized `ps2_clk` then goes through a glitch filter:
  - The filtered clock `fclk` changes only after `FILTER_LEN` consecutive identical samples.
  - `fclk` resets to 1.
- A falling edge is a cycle in which `fclk` goes from 1 to 0. Synchronized data is sampled in that same cycle.

**Frame state machine**
- States: `IDLE`, `SHIFT`, `CHECK`.
- `IDLE`, on a falling edge:
  - data = 0 (start bit): go to `SHIFT` with bit count 1.
  - data = 1: stay in `IDLE` and pulse `frame_err`.
- `SHIFT`, on each falling edge: shift the sampled bit in and increment the count.
  - Data arrives LSB first in bits 1–8; bit 9 is odd parity; bit 10 is the stop bit.
  - When the 11th bit (the stop bit) is sampled, go to `CHECK`.
- `CHECK` lasts one cycle, then returns to `IDLE`. The frame is valid only if the stop bit is 1 and parity is odd across the 8 data bits plus the parity bit.
- Timeout: in `SHIFT`, a counter reloads on each falling edge. If it reaches `TIMEOUT_CYCLES` with no edge:
  - go to `IDLE` and pulse `frame_err`;
  - clear the prefix flags.

**Byte interpretation** (valid frames only, in `CHECK`)
- `E0`: set `ext`. No output strobe.
- `F0`: set `brk`. No output strobe.
- Any other byte:
  - `scancode` ← {`ext`, byte};
  - pulse `Released` if `brk` = 1, otherwise pulse `Pressed`;
  - clear `ext` and `brk`.
- Invalid frame: pulse `frame_err`, discard the byte, clear `ext` and `brk`. `scancode` is unchanged.
- Typematic repeats from the keyboard produce repeated `Pressed` pulses. No deduplication is done.
- Prefix order `E0 F0 xx` and `F0` followed by a non-prefix byte are both legal. `F0 E0 xx` also sets both flags and yields an extended break.

**Reset values**
- `scancode` = 9'h000.
- `Pressed`, `Released`, `frame_err` = 0.
- `fclk` = 1, state = `IDLE`, `ext` = `brk` = 0, counters = 0.
- Asserting `rst` mid-frame discards the partial frame and any pending prefixes. No strobe is issued.

## Timing

**Latency**
- A raw `ps2_clk` fall becomes a detected edge 2 (sync) + `FILTER_LEN` cycles later.
- The stop-bit edge is detected in cycle N. `CHECK` is in cycle N+1, and `scancode`, `Pressed`/`Released`/`frame_err` are all registered and visible in cycle N+2.

**Output strobes**
- `scancode` changes in the same cycle its strobe is high and is stable from that cycle onward. A consumer triggered on the rising edge of `Released` therefore sees a valid code.
- At most one of `Pressed`, `Released`, `frame_err` is high in any cycle.
- Each strobe is exactly 1 cycle wide.

**Edge cases**
- A falling edge during the `CHECK` cycle cannot occur at PS/2 rates. If it does, it is ignored.
- Timeout and a falling edge in the same cycle: the edge wins and the counter reloads.

## Test plan

- **Make code:** send frame `1C` (parity 0), `FILTER_LEN` = 8, bit period 40 µs → one `Pressed` pulse, `scancode` = 9'h01C, `Released` stays 0.
- **Break code:** send `F0` then `1C` → no strobe after `F0`; after `1C`, one `Released` pulse with `scancode` = 9'h01C.
- **Extended break:** send `E0`, `F0`, `75` → one `Released` pulse, `scancode` = 9'h175. A following plain `75` gives a `Pressed` pulse with `scancode` = 9'h075 (flags were cleared).
- **Frame errors:**
  - `1C` with its parity bit flipped → `frame_err` pulse, no other strobe, `scancode` unchanged.
  - Stop bit = 0 → same response.
- **Glitch and timeout:**
  - A 3-cycle low glitch on `ps2_clk` → no bit is shifted.
  - Stop clocking after 5 bits for more than `TIMEOUT_CYCLES` → `frame_err`; a following clean `F0`, `1C` still decodes correctly as `Released` with 9'h01C.
- **Reset mid-frame:** send `F0`, assert `rst` for 1 cycle partway through the next frame, then send a clean `1C` → `Pressed` (not `Released`), `scancode` = 9'h01C. All outputs are 0 and `scancode` is 9'h000 during reset.
